// File: rtl/tone_seq_pkg.sv
// Shared register map, control bit positions, FSM encoding and entry field helpers
// for the programmable tone sequencer.
package tone_seq_pkg;

  localparam logic [7:0] ADDR_CTRL = 8'd0;
  localparam logic [7:0] ADDR_LEN  = 8'd1;
  localparam logic [7:0] ADDR_LOOP = 8'd2;
  localparam logic [7:0] ADDR_GAP  = 8'd3;
  localparam logic [7:0] ADDR_STAT = 8'd4;
  localparam logic [7:0] ADDR_RAM  = 8'd16;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_OUTEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } seqState_t;

  function automatic logic [15:0] entryDur(input logic [31:0] e);
    return e[31:16];
  endfunction

  function automatic logic [15:0] entryDiv(input logic [31:0] e);
    return e[15:0];
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles every div*PRESCALE clocks, held low while clr or div==0.
// Output is registered; clr takes effect on the next clock.
module tone_gen #(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic [15:0] div,
  output logic        tone
);

  localparam int PH_W = 16 + $clog2(PRESCALE + 1);

  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] halfPeriod;

  assign halfPeriod = PH_W'(div) * PH_W'(PRESCALE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase <= '0;
      tone  <= 1'b0;
    end else if (clr || div == 16'd0) begin
      phase <= '0;
      tone  <= 1'b0;
    end else if (phase == halfPeriod - PH_W'(1)) begin
      phase <= '0;
      tone  <= ~tone;
    end else begin
      phase <= phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Bus-programmable tone sequencer: plays {dur_ms, div} entries from a sequence RAM with
// looping and inter-loop gaps; register reads return one cycle after addrOut.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int CLK_FRE   = 50000000,
  parameter int SEQ_DEPTH = 64,
  parameter int N_OUT     = 2,
  parameter int PRESCALE  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       addrIn,
  input  logic [7:0]       addrOut,
  input  logic [3:0]       sizeDecode,
  input  logic [31:0]      dataIn,
  output logic [31:0]      dataOut,
  output logic [N_OUT-1:0] tone_out,
  output logic             done_pulse
);

  localparam int MS_CYCLES = CLK_FRE / 1000;
  localparam int MS_W      = $clog2(MS_CYCLES + 1);
  localparam int IDX_W     = $clog2(SEQ_DEPTH);
  localparam logic [8:0] RAM_END = 9'(16 + SEQ_DEPTH);

  logic [N_OUT-1:0] outEn;
  logic [7:0]       lenReg;
  logic [15:0]      loopReg;
  logic [15:0]      gapReg;

  seqState_t   state;
  logic [7:0]  pos;
  logic [7:0]  lenLat;
  logic        loopInf;
  logic [15:0] loopsLeft;
  logic [15:0] gapLat;
  logic [15:0] curDur;
  logic [15:0] curDiv;
  logic [MS_W-1:0] msCnt;
  logic [15:0] msElapsed;

  logic [31:0] ram [SEQ_DEPTH];

  logic             startReq, stopReq;
  logic             wrInRam, rdInRam;
  logic [IDX_W-1:0] wrIdx, rdIdx;
  logic [31:0]      loadEntry, rdMux;
  logic [15:0]      loadDur;
  logic             msWrap, entryEnd, gapEnd, lastEntry, reloop;
  logic             toneRaw;

  assign startReq = (addrIn == ADDR_CTRL) && sizeDecode[0] && dataIn[CTRL_START];
  assign stopReq  = (addrIn == ADDR_CTRL) && sizeDecode[0] && dataIn[CTRL_STOP];

  assign wrInRam = (addrIn >= ADDR_RAM) && ({1'b0, addrIn} < RAM_END);
  assign rdInRam = (addrOut >= ADDR_RAM) && ({1'b0, addrOut} < RAM_END);
  assign wrIdx   = IDX_W'(addrIn - ADDR_RAM);
  assign rdIdx   = IDX_W'(addrOut - ADDR_RAM);

  always_ff @(posedge clk) begin
    if (wrInRam) begin
      for (int b = 0; b < 4; b++) begin
        if (sizeDecode[b]) ram[wrIdx][8*b +: 8] <= dataIn[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outEn   <= '0;
      lenReg  <= '0;
      loopReg <= '0;
      gapReg  <= '0;
    end else begin
      if (addrIn == ADDR_CTRL && sizeDecode[1]) outEn <= dataIn[CTRL_OUTEN +: N_OUT];
      if (addrIn == ADDR_LEN && sizeDecode[0]) lenReg <= dataIn[7:0];
      if (addrIn == ADDR_LOOP) begin
        if (sizeDecode[0]) loopReg[7:0]  <= dataIn[7:0];
        if (sizeDecode[1]) loopReg[15:8] <= dataIn[15:8];
      end
      if (addrIn == ADDR_GAP) begin
        if (sizeDecode[0]) gapReg[7:0]  <= dataIn[7:0];
        if (sizeDecode[1]) gapReg[15:8] <= dataIn[15:8];
      end
    end
  end

  always_comb begin
    rdMux = '0;
    case (addrOut)
      ADDR_CTRL: rdMux[CTRL_OUTEN +: N_OUT] = outEn;
      ADDR_LEN:  rdMux[7:0]  = lenReg;
      ADDR_LOOP: rdMux[15:0] = loopReg;
      ADDR_GAP:  rdMux[15:0] = gapReg;
      ADDR_STAT: rdMux = {loopsLeft, pos, 6'd0, state == ST_GAP, state != ST_IDLE};
      default:   if (rdInRam) rdMux = ram[rdIdx];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dataOut <= '0;
    else       dataOut <= rdMux;
  end

  assign loadEntry = ram[pos[IDX_W-1:0]];
  assign loadDur   = entryDur(loadEntry);
  assign msWrap    = (msCnt == MS_W'(MS_CYCLES - 1));
  // A zero-duration entry ends in its LOAD cycle, so it is skipped without playing.
  assign entryEnd  = (state == ST_LOAD && loadDur == 16'd0) ||
                     (state == ST_PLAY && msWrap && msElapsed == curDur - 16'd1);
  assign gapEnd    = (state == ST_GAP) && msWrap && (msElapsed == gapLat - 16'd1);
  assign lastEntry = ({1'b0, pos} + 9'd1) >= {1'b0, lenLat};
  assign reloop    = loopInf || (loopsLeft > 16'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      pos        <= '0;
      lenLat     <= '0;
      loopInf    <= 1'b0;
      loopsLeft  <= '0;
      gapLat     <= '0;
      curDur     <= '0;
      curDiv     <= '0;
      msCnt      <= '0;
      msElapsed  <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (stopReq) begin
        state <= ST_IDLE;
      end else if (startReq && lenReg != 8'd0) begin
        state     <= ST_LOAD;
        pos       <= '0;
        lenLat    <= lenReg;
        loopInf   <= (loopReg == 16'd0);
        loopsLeft <= loopReg;
        gapLat    <= gapReg;
      end else begin
        case (state)
          ST_LOAD: begin
            curDur    <= loadDur;
            curDiv    <= entryDiv(loadEntry);
            msCnt     <= '0;
            msElapsed <= '0;
            state     <= ST_PLAY;
          end
          ST_PLAY, ST_GAP: begin
            if (msWrap) begin
              msCnt     <= '0;
              msElapsed <= msElapsed + 16'd1;
            end else begin
              msCnt <= msCnt + MS_W'(1);
            end
          end
          default: ;
        endcase

        if (gapEnd) begin
          pos   <= '0;
          state <= ST_LOAD;
        end

        if (entryEnd) begin
          msCnt     <= '0;
          msElapsed <= '0;
          if (!lastEntry) begin
            pos   <= pos + 8'd1;
            state <= ST_LOAD;
          end else if (reloop) begin
            if (!loopInf) loopsLeft <= loopsLeft - 16'd1;
            pos   <= '0;
            state <= (gapLat == 16'd0) ? ST_LOAD : ST_GAP;
          end else begin
            loopsLeft  <= '0;
            state      <= ST_IDLE;
            done_pulse <= 1'b1;
          end
        end
      end
    end
  end

  tone_gen #(
    .PRESCALE(PRESCALE)
  ) u_toneGen (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state != ST_PLAY),
    .div  (curDiv),
    .tone (toneRaw)
  );

  // Gating by state forces the pins low the same cycle playback leaves PLAY.
  assign tone_out = (toneRaw && state == ST_PLAY) ? outEn : '0;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with MS_CYCLES=100, PRESCALE=1, SEQ_DEPTH=8, N_OUT=2.
module tb_tone_sequencer;

  logic        clk;
  logic        rstn;
  logic [7:0]  addrIn;
  logic [7:0]  addrOut;
  logic [3:0]  sizeDecode;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic [1:0]  tone_out;
  logic        done_pulse;

  int nAsserts = 0;
  int nFails   = 0;

  logic [1:0]  tSamp [0:599];
  logic        dSamp [0:599];
  logic [31:0] rSamp [0:599];

  tone_sequencer #(
    .CLK_FRE   (100000),
    .SEQ_DEPTH (8),
    .N_OUT     (2),
    .PRESCALE  (1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .addrIn     (addrIn),
    .addrOut    (addrOut),
    .sizeDecode (sizeDecode),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .tone_out   (tone_out),
    .done_pulse (done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    addrIn     = a;
    dataIn     = d;
    sizeDecode = be;
    @(negedge clk);
    sizeDecode = 4'b0000;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    addrOut = a;
    @(negedge clk);
    v = dataOut;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tSamp[i] = tone_out;
      dSamp[i] = done_pulse;
      rSamp[i] = dataOut;
    end
  endtask

  function automatic int doneCount(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (dSamp[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int doneFirst(input int n);
    for (int i = 0; i < n; i++) if (dSamp[i] === 1'b1) return i;
    return -1;
  endfunction

  initial begin
    logic [31:0] v;
    logic [1:0]  e;
    int errs;

    rstn = 1'b0; addrIn = 8'd0; addrOut = 8'd0; sizeDecode = 4'b0000; dataIn = 32'd0;
    repeat (3) @(negedge clk);
    check("reset tone_out", {30'd0, tone_out}, 32'd0);
    check("reset done_pulse", {31'd0, done_pulse}, 32'd0);
    check("reset dataOut", dataOut, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    rd(8'd0, v); check("reset CTRL", v, 32'd0);
    rd(8'd1, v); check("reset LEN", v, 32'd0);
    rd(8'd2, v); check("reset LOOP", v, 32'd0);
    rd(8'd3, v); check("reset GAP", v, 32'd0);
    rd(8'd4, v); check("reset STAT", v, 32'd0);

    // single entry {2 ms, div 10}, BUZ only
    wr(8'd16, 32'h0002_000A, 4'hF);
    wr(8'd1, 32'd1, 4'hF);
    wr(8'd2, 32'd1, 4'hF);
    wr(8'd0, 32'h0000_0100, 4'b0010);
    wr(8'd0, 32'h0000_0001, 4'b0001);
    capture(205);
    errs = 0;
    for (int i = 0; i < 205; i++) begin
      e = (i < 200 && ((i / 10) % 2) == 1) ? 2'b01 : 2'b00;
      if (tSamp[i] !== e) errs++;
    end
    check("t1 tone pattern errors", errs, 0);
    check("t1 done count", doneCount(205), 1);
    check("t1 done position", doneFirst(205), 200);
    rd(8'd4, v); check("t1 STAT after done", v, 32'd0);

    // three entries, middle has zero duration, last is a rest; both pins enabled
    wr(8'd16, 32'h0001_0005, 4'hF);
    wr(8'd17, 32'h0000_0007, 4'hF);
    wr(8'd18, 32'h0001_0000, 4'hF);
    wr(8'd1, 32'd3, 4'hF);
    wr(8'd0, 32'h0000_0300, 4'b0010);
    wr(8'd0, 32'h0000_0001, 4'b0001);
    capture(210);
    errs = 0;
    for (int i = 0; i < 210; i++) begin
      e = (i < 100 && ((i / 5) % 2) == 1) ? 2'b11 : 2'b00;
      if (tSamp[i] !== e) errs++;
    end
    check("t2 tone pattern errors", errs, 0);
    check("t2 done count", doneCount(210), 1);
    check("t2 done position", doneFirst(210), 202);

    // two loops with a 3 ms gap, watching STAT
    wr(8'd16, 32'h0001_0004, 4'hF);
    wr(8'd1, 32'd1, 4'hF);
    wr(8'd2, 32'd2, 4'hF);
    wr(8'd3, 32'd3, 4'hF);
    wr(8'd0, 32'h0000_0100, 4'b0010);
    addrOut = 8'd4;
    wr(8'd0, 32'h0000_0001, 4'b0001);
    capture(510);
    errs = 0;
    for (int i = 0; i < 510; i++) begin
      if (i < 100)                 e = (((i / 4) % 2) == 1) ? 2'b01 : 2'b00;
      else if (i >= 401 && i <= 500) e = ((((i - 401) / 4) % 2) == 1) ? 2'b01 : 2'b00;
      else                         e = 2'b00;
      if (tSamp[i] !== e) errs++;
    end
    check("t3 tone pattern errors", errs, 0);
    check("t3 STAT while playing", rSamp[50], 32'h0002_0001);
    check("t3 STAT during gap", rSamp[250], 32'h0001_0003);
    check("t3 done count", doneCount(510), 1);
    check("t3 done position", doneFirst(510), 501);

    // infinite loop, STOP while tone is high
    wr(8'd2, 32'd0, 4'hF);
    wr(8'd0, 32'h0000_0001, 4'b0001);
    capture(446);
    errs = 0;
    for (int i = 0; i < 446; i++) begin
      if (i < 100)       e = (((i / 4) % 2) == 1) ? 2'b01 : 2'b00;
      else if (i >= 401) e = ((((i - 401) / 4) % 2) == 1) ? 2'b01 : 2'b00;
      else               e = 2'b00;
      if (tSamp[i] !== e) errs++;
    end
    check("t4 tone pattern errors", errs, 0);
    check("t4 STAT during infinite gap", rSamp[250], 32'h0000_0003);
    check("t4 no done before stop", doneCount(446), 0);
    wr(8'd0, 32'h0000_0002, 4'b0001);
    check("t4 tone after stop", {30'd0, tone_out}, 32'd0);
    capture(20);
    check("t4 no done after stop", doneCount(20), 0);
    errs = 0;
    for (int i = 0; i < 20; i++) if (tSamp[i] !== 2'b00) errs++;
    check("t4 tone stays low", errs, 0);
    rd(8'd4, v); check("t4 STAT after stop", v, 32'd0);

    // START with LEN=0 is ignored; START|STOP together stops
    wr(8'd1, 32'd0, 4'hF);
    wr(8'd0, 32'h0000_0001, 4'b0001);
    rd(8'd4, v); check("t5 STAT after LEN0 start", v, 32'd0);
    wr(8'd1, 32'd1, 4'hF);
    wr(8'd0, 32'h0000_0001, 4'b0001);
    repeat (5) @(negedge clk);
    rd(8'd4, v); check("t5 STAT busy", v, 32'h0000_0001);
    wr(8'd0, 32'h0000_0003, 4'b0001);
    check("t5 tone after start+stop", {30'd0, tone_out}, 32'd0);
    rd(8'd4, v); check("t5 STAT after start+stop", v, 32'd0);
    capture(10);
    check("t5 no done after start+stop", doneCount(10), 0);

    // byte lanes, readback, unmapped address
    wr(8'd3, 32'd0, 4'hF);
    wr(8'd3, 32'hAABB_CCDD, 4'b0010);
    rd(8'd3, v); check("t6 GAP byte write", v, 32'h0000_CC00);
    rd(8'd16, v); check("t6 RAM entry0", v, 32'h0001_0004);
    rd(8'd17, v); check("t6 RAM entry1", v, 32'h0000_0007);
    rd(8'd0, v); check("t6 CTRL readback", v, 32'h0000_0100);
    wr(8'd5, 32'hFFFF_FFFF, 4'hF);
    rd(8'd5, v); check("t6 unmapped read", v, 32'd0);

    // reset while the tone is high
    wr(8'd3, 32'd0, 4'hF);
    wr(8'd0, 32'h0000_0001, 4'b0001);
    capture(6);
    check("t7 tone high before reset", {30'd0, tSamp[5]}, 32'd1);
    rstn = 1'b0;
    #1;
    check("t7 tone during reset", {30'd0, tone_out}, 32'd0);
    check("t7 dataOut during reset", dataOut, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    rd(8'd1, v); check("t7 LEN after reset", v, 32'd0);
    rd(8'd4, v); check("t7 STAT after reset", v, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
